// File: rtl/video_dram_arb.sv
`default_nettype none
// ============================================================================
// Module      : video_dram_arb
// Description : Slot-based DRAM read arbiter for one video fetcher and two
//               block requesters (tile-map TM, sprite-render TS). Each DRAM
//               slot is 4 clocks long and ends with a c3 pulse. Arbitration
//               for the following slot happens combinationally in the c3
//               cycle; the winner, mem_req and mem_addr load on the edge
//               that ends c3. Video owns the first min(bw[3:0]+1, window)
//               slots of each 8- or 16-slot window; other slots go to
//               TM, then TS, else stay idle.
// Ports       : clk, res           - clock, synchronous active-high reset
//               c3                 - last cycle of the current slot
//               video_go/addr/bw   - video window enable, address, bandwidth
//               video_pre_next     - video wins the next slot (c3 cycle)
//               video_next         - video slot completing (c3 cycle)
//               video_strobe       - dram_rdata holds video data
//               tm_req/ts_req      - requester reads, tm_addr/ts_addr
//               ts_pre_next        - TS wins the next slot (c3 cycle)
//               tm_next/ts_next    - requester slot completing (c3 cycle)
//               mem_req/mem_addr   - DRAM request, held for the whole slot
//               mem_rdata          - DRAM data, valid in the c3 cycle
//               dram_rdata         - registered copy of mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
module video_dram_arb #(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              res,
  input  logic              c3,
  input  logic              video_go,
  input  logic [ADDR_W-1:0] video_addr,
  input  logic [4:0]        video_bw,
  output logic              video_pre_next,
  output logic              video_next,
  output logic              video_strobe,
  input  logic              tm_req,
  input  logic              ts_req,
  input  logic [ADDR_W-1:0] tm_addr,
  input  logic [ADDR_W-1:0] ts_addr,
  output logic              ts_pre_next,
  output logic              tm_next,
  output logic              ts_next,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       dram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_TM   = 2'd2,
    OWN_TS   = 2'd3
  } owner_t;

  owner_t            r_owner;
  owner_t            w_owner_nxt;
  owner_t            w_arb;
  logic [ADDR_W-1:0] w_arb_addr;

  logic [3:0]        r_slot;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_dram_rdata;
  logic              r_video_strobe;

  logic [4:0]        w_vid_cnt;
  logic [4:0]        w_win_len;
  logic [4:0]        w_vid_lim;
  logic [3:0]        w_slot_last;
  logic              w_vid_slot;

  // Video slot budget is clipped to the window so bw[3:0]=15 in an
  // 8-slot window still leaves the counter range consistent.
  assign w_vid_cnt   = {1'b0, video_bw[3:0]} + 5'd1;
  assign w_win_len   = video_bw[4] ? 5'd16 : 5'd8;
  assign w_vid_lim   = (w_vid_cnt < w_win_len) ? w_vid_cnt : w_win_len;
  assign w_slot_last = video_bw[4] ? 4'd15 : 4'd7;
  assign w_vid_slot  = video_go && ({1'b0, r_slot} < w_vid_lim);

  // Arbitration result and owner next-state
  always_comb begin
    w_arb       = OWN_NONE;
    w_arb_addr  = r_mem_addr;
    w_owner_nxt = r_owner;
    if (w_vid_slot) begin
      w_arb      = OWN_VID;
      w_arb_addr = video_addr;
    end else if (tm_req) begin
      w_arb      = OWN_TM;
      w_arb_addr = tm_addr;
    end else if (ts_req) begin
      w_arb      = OWN_TS;
      w_arb_addr = ts_addr;
    end
    if (c3) begin
      w_owner_nxt = w_arb;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Single-gate decodes of c3 and registered/arbitrated state
  assign video_pre_next = c3 && (w_arb == OWN_VID);
  assign ts_pre_next    = c3 && (w_arb == OWN_TS);
  assign video_next     = c3 && (r_owner == OWN_VID);
  assign tm_next        = c3 && (r_owner == OWN_TM);
  assign ts_next        = c3 && (r_owner == OWN_TS);

  always_ff @(posedge clk) begin
    if (res) begin
      r_slot         <= 4'd0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_dram_rdata   <= 16'd0;
      r_video_strobe <= 1'b0;
    end else begin
      if (c3) begin
        r_mem_req    <= (w_arb != OWN_NONE);
        r_mem_addr   <= w_arb_addr;
        r_dram_rdata <= mem_rdata;
      end
      r_video_strobe <= video_next;
      // Counter past the window end (window shrunk) still wraps at once.
      if (!video_go) begin
        r_slot <= 4'd0;
      end else if (c3) begin
        r_slot <= (r_slot >= w_slot_last) ? 4'd0 : r_slot + 4'd1;
      end
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign dram_rdata   = r_dram_rdata;
  assign video_strobe = r_video_strobe;

endmodule
`default_nettype wire

// File: tb/tb_video_dram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_dram_arb
// Description : Scoreboard bench for video_dram_arb. Stimulus pushes the
//               expected owner/address of every granted slot; a monitor pops
//               an entry on each *_next pulse and checks the following
//               strobe and dram_rdata.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_dram_arb;

  localparam int ADDR_W = 21;

  logic              clk = 1'b0;
  logic              res;
  logic              c3;
  logic              video_go;
  logic [ADDR_W-1:0] video_addr;
  logic [4:0]        video_bw;
  logic              video_pre_next;
  logic              video_next;
  logic              video_strobe;
  logic              tm_req;
  logic              ts_req;
  logic [ADDR_W-1:0] tm_addr;
  logic [ADDR_W-1:0] ts_addr;
  logic              ts_pre_next;
  logic              tm_next;
  logic              ts_next;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       dram_rdata;

  video_dram_arb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .res(res), .c3(c3), .video_go(video_go),
    .video_addr(video_addr), .video_bw(video_bw),
    .video_pre_next(video_pre_next), .video_next(video_next),
    .video_strobe(video_strobe), .tm_req(tm_req), .ts_req(ts_req),
    .tm_addr(tm_addr), .ts_addr(ts_addr), .ts_pre_next(ts_pre_next),
    .tm_next(tm_next), .ts_next(ts_next), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dram_rdata(dram_rdata)
  );

  always #5 clk = ~clk;

  // DRAM model: data is a fixed function of the address
  assign mem_rdata = mem_addr[15:0] ^ 16'hA5A5;

  typedef struct {
    logic [1:0]        kind;   // 1=VID 2=TM 3=TS
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
    end
  endtask

  // One 4-clk slot. Checks mem_req in the first cycle and the pre_next
  // decodes in the c3 cycle; pushes the expected grant made at this c3.
  task automatic run_slot(input logic exp_mreq, input logic exp_vpre,
                          input logic exp_tspre, input logic [1:0] push_kind,
                          input logic [ADDR_W-1:0] push_addr);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      c3 = (i == 3);
      @(negedge clk);
      if (i == 0) chk("mem_req", {31'd0, mem_req}, {31'd0, exp_mreq});
      if (i == 3) begin
        chk("video_pre_next", {31'd0, video_pre_next}, {31'd0, exp_vpre});
        chk("ts_pre_next", {31'd0, ts_pre_next}, {31'd0, exp_tspre});
        if (push_kind != 2'd0) begin
          e.kind = push_kind;
          e.addr = push_addr;
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    c3 = 1'b0;
  endtask

  // Monitor / scoreboard
  logic              r_strb_pend = 1'b0;
  logic              r_rd_pend   = 1'b0;
  logic [15:0]       r_rd_exp    = 16'd0;

  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  kind;
    if (!res) begin
      if (r_strb_pend || video_strobe)
        chk("video_strobe", {31'd0, video_strobe}, {31'd0, r_strb_pend});
      if (r_rd_pend)
        chk("dram_rdata", {16'd0, dram_rdata}, {16'd0, r_rd_exp});
      r_strb_pend = 1'b0;
      r_rd_pend   = 1'b0;
      kind = 2'd0;
      if ((32'(video_next) + 32'(tm_next) + 32'(ts_next)) > 1) begin
        chk("next_onehot", 32'd1, 32'd0);
      end
      if (video_next) kind = 2'd1;
      else if (tm_next) kind = 2'd2;
      else if (ts_next) kind = 2'd3;
      if (kind != 2'd0) begin
        if (q.size() == 0) begin
          chk("unexpected_next", {30'd0, kind}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("next_owner", {30'd0, kind}, {30'd0, e.kind});
          chk("next_mem_addr", {11'd0, mem_addr}, {11'd0, e.addr});
          r_strb_pend = (e.kind == 2'd1);
          r_rd_pend   = 1'b1;
          r_rd_exp    = e.addr[15:0] ^ 16'hA5A5;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with c3 and a request active: reset must win.
    res = 1'b1; c3 = 1'b1; video_go = 1'b0; video_addr = '0; video_bw = 5'd0;
    tm_req = 1'b1; ts_req = 1'b0; tm_addr = 21'h7ff; ts_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {11'd0, mem_addr}, 32'd0);
    chk("rst_dram_rdata", {16'd0, dram_rdata}, 32'd0);
    chk("rst_video_strobe", {31'd0, video_strobe}, 32'd0);
    chk("rst_tm_next", {31'd0, tm_next}, 32'd0);
    res = 1'b0; c3 = 1'b0; tm_req = 1'b0; tm_addr = '0;

    // No requests: idle slots
    repeat (3) run_slot(1'b0, 1'b0, 1'b0, 2'd0, '0);

    // TM beats TS; drop TM -> TS
    tm_req = 1'b1; ts_req = 1'b1; tm_addr = 21'h00200; ts_addr = 21'h00300;
    run_slot(1'b0, 1'b0, 1'b0, 2'd2, 21'h00200);
    repeat (3) run_slot(1'b1, 1'b0, 1'b0, 2'd2, 21'h00200);
    tm_req = 1'b0;
    repeat (2) run_slot(1'b1, 1'b0, 1'b1, 2'd3, 21'h00300);
    ts_req = 1'b0;
    run_slot(1'b1, 1'b0, 1'b0, 2'd0, '0);

    // bw=00011, TM constant: 4 VID + 4 TM per 8-slot window
    video_go = 1'b1; video_bw = 5'b00011; tm_req = 1'b1;
    tm_addr = 21'h00400; video_addr = 21'h01000;
    for (int i = 0; i < 16; i++) begin
      if ((i % 8) < 4)
        run_slot(i != 0, 1'b1, 1'b0, 2'd1, 21'h01000);
      else
        run_slot(1'b1, 1'b0, 1'b0, 2'd2, 21'h00400);
    end
    video_go = 1'b0; tm_req = 1'b0;
    run_slot(1'b1, 1'b0, 1'b0, 2'd0, '0);

    // bw=11111: all 16 slots video, address tracks video_addr
    video_go = 1'b1; video_bw = 5'b11111;
    for (int i = 0; i < 16; i++) begin
      video_addr = 21'h02000 + 21'(i);
      run_slot(i != 0, 1'b1, 1'b0, 2'd1, 21'h02000 + 21'(i));
    end
    video_go = 1'b0;
    run_slot(1'b1, 1'b0, 1'b0, 2'd0, '0);

    // bw 00111 -> 00001 with counter at 3
    video_go = 1'b1; video_bw = 5'b00111; tm_req = 1'b1;
    tm_addr = 21'h00500; video_addr = 21'h03000;
    for (int i = 0; i < 3; i++) run_slot(i != 0, 1'b1, 1'b0, 2'd1, 21'h03000);
    video_bw = 5'b00001;
    repeat (5) run_slot(1'b1, 1'b0, 1'b0, 2'd2, 21'h00500);
    for (int i = 0; i < 8; i++) begin
      if (i < 2) run_slot(1'b1, 1'b1, 1'b0, 2'd1, 21'h03000);
      else       run_slot(1'b1, 1'b0, 1'b0, 2'd2, 21'h00500);
    end
    video_go = 1'b0; tm_req = 1'b0;
    run_slot(1'b1, 1'b0, 1'b0, 2'd0, '0);

    // Reset in the second clk of a TM slot aborts it
    tm_req = 1'b1; tm_addr = 21'h00600;
    run_slot(1'b0, 1'b0, 1'b0, 2'd0, '0);     // grant that will be aborted
    c3 = 1'b0;
    @(negedge clk);
    chk("abort_pre_mem_req", {31'd0, mem_req}, 32'd1);
    chk("abort_pre_mem_addr", {11'd0, mem_addr}, 32'h00600);
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_mem_addr", {11'd0, mem_addr}, 32'd0);
    chk("abort_dram_rdata", {16'd0, dram_rdata}, 32'd0);
    @(posedge clk); #1;
    c3 = 1'b1;
    @(negedge clk);
    chk("abort_tm_next", {31'd0, tm_next}, 32'd0);
    begin
      exp_t e;
      e.kind = 2'd2;
      e.addr = 21'h00600;
      q.push_back(e);
    end
    @(posedge clk); #1;
    c3 = 1'b0; tm_req = 1'b0;
    run_slot(1'b1, 1'b0, 1'b0, 2'd0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
